// File: rtl/nec_pkg.sv
// Shared types and default timing windows (microseconds) for the NEC infrared frame decoder.
package nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } nec_state_t;

    localparam int unsigned NEC_LM_MIN  = 8000;
    localparam int unsigned NEC_LM_MAX  = 10000;
    localparam int unsigned NEC_LS_MIN  = 4000;
    localparam int unsigned NEC_LS_MAX  = 5000;
    localparam int unsigned NEC_RS_MIN  = 2000;
    localparam int unsigned NEC_RS_MAX  = 2500;
    localparam int unsigned NEC_BM_MIN  = 400;
    localparam int unsigned NEC_BM_MAX  = 750;
    localparam int unsigned NEC_S0_MIN  = 400;
    localparam int unsigned NEC_S0_MAX  = 750;
    localparam int unsigned NEC_S1_MIN  = 1400;
    localparam int unsigned NEC_S1_MAX  = 1900;
    localparam int unsigned NEC_TIMEOUT = 12000;

    // Inclusive window test on a 16-bit microsecond duration.
    function automatic logic in_win(input logic [15:0] d, input int unsigned lo, input int unsigned hi);
        return ({16'h0, d} >= lo) && ({16'h0, d} <= hi);
    endfunction

    // Address and command bytes each followed by their bitwise inverse.
    function automatic logic inv_ok(input logic [31:0] w);
        return (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
    endfunction

endpackage

// File: rtl/nec_frame_decoder_if.sv
// Signal bundle between the NEC decoder (master) and its pin/timer/consumer environment (slave).
interface nec_frame_decoder_if #(
    parameter int CNT_W = 33
);
    logic             ir_in;
    logic [CNT_W-1:0] count;
    logic             tmr_rst;
    logic [7:0]       addr;
    logic [7:0]       cmd;
    logic             data_valid;
    logic             repeat_pulse;
    logic             frame_err;

    modport master (
        input  ir_in, count,
        output tmr_rst, addr, cmd, data_valid, repeat_pulse, frame_err
    );

    modport slave (
        output ir_in, count,
        input  tmr_rst, addr, cmd, data_valid, repeat_pulse, frame_err
    );
endinterface

// File: rtl/ir_sync_edge.sv
// Two-flop synchroniser for the raw IR pin, polarity normalisation to "mark",
// and registered mark-start / mark-end event pulses (3 clk pin-to-event on both edges).
module ir_sync_edge #(
    parameter bit IR_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ir_in,
    output logic mark_start,
    output logic mark_end
);
    localparam logic IDLE_PIN = IR_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic sync_p0;
    logic sync_p1;
    logic mark_p1;
    logic mark_p2;

    assign mark_p1 = IR_ACTIVE_LOW ? ~sync_p1 : sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0    <= IDLE_PIN;
            sync_p1    <= IDLE_PIN;
            mark_p2    <= 1'b0;
            mark_start <= 1'b0;
            mark_end   <= 1'b0;
        end else begin
            sync_p0    <= ir_in;
            sync_p1    <= sync_p0;
            // stage 2: registered level and edge pulses
            mark_p2    <= mark_p1;
            mark_start <= mark_p1 & ~mark_p2;
            mark_end   <= ~mark_p1 & mark_p2;
        end
    end
endmodule

// File: rtl/nec_frame_decoder.sv
// NEC IR frame decoder: measures each mark/space with the external microsecond timer and
// assembles 32-bit frames. Define NEC_CHECK_EN to require inverse address/command bytes.
module nec_frame_decoder
    import nec_pkg::*;
#(
    parameter int          CNT_W         = 33,
    parameter bit          IR_ACTIVE_LOW = 1'b1,
    parameter int unsigned LM_MIN        = NEC_LM_MIN,
    parameter int unsigned LM_MAX        = NEC_LM_MAX,
    parameter int unsigned LS_MIN        = NEC_LS_MIN,
    parameter int unsigned LS_MAX        = NEC_LS_MAX,
    parameter int unsigned RS_MIN        = NEC_RS_MIN,
    parameter int unsigned RS_MAX        = NEC_RS_MAX,
    parameter int unsigned BM_MIN        = NEC_BM_MIN,
    parameter int unsigned BM_MAX        = NEC_BM_MAX,
    parameter int unsigned S0_MIN        = NEC_S0_MIN,
    parameter int unsigned S0_MAX        = NEC_S0_MAX,
    parameter int unsigned S1_MIN        = NEC_S1_MIN,
    parameter int unsigned S1_MAX        = NEC_S1_MAX,
    parameter int unsigned TIMEOUT       = NEC_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    nec_frame_decoder_if.master bus
);
    nec_state_t  state;
    logic [31:0] sr;
    logic [4:0]  bitcnt;
    logic        rpt;
    logic        mark_start;
    logic        mark_end;
    logic        ev;
    logic        timeout;
    logic [15:0] dur;
    logic        unused_cnt_hi;

    ir_sync_edge #(
        .IR_ACTIVE_LOW (IR_ACTIVE_LOW)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .ir_in      (bus.ir_in),
        .mark_start (mark_start),
        .mark_end   (mark_end)
    );

    // The timer saturates at 16'hFFFF, so only the low 16 bits carry the duration.
    assign dur           = bus.count[15:0];
    assign unused_cnt_hi = ^bus.count[CNT_W-1:16];
    assign ev            = mark_start | mark_end;
    // While tmr_rst is in flight the count still holds the previous (possibly saturated) phase.
    assign timeout       = (state != IDLE) && !bus.tmr_rst && ({16'h0, dur} >= TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            sr               <= 32'h0;
            bitcnt           <= 5'd0;
            rpt              <= 1'b0;
            bus.tmr_rst      <= 1'b1;
            bus.addr         <= 8'h00;
            bus.cmd          <= 8'h00;
            bus.data_valid   <= 1'b0;
            bus.repeat_pulse <= 1'b0;
            bus.frame_err    <= 1'b0;
        end else begin
            bus.tmr_rst      <= ev;
            bus.data_valid   <= 1'b0;
            bus.repeat_pulse <= 1'b0;
            bus.frame_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mark_start) state <= LEAD_MARK;
                end
                LEAD_MARK: begin
                    if (ev) begin
                        if (mark_end && in_win(dur, LM_MIN, LM_MAX)) begin
                            state <= LEAD_SPACE;
                        end else begin
                            state         <= IDLE;
                            bus.frame_err <= 1'b1;
                        end
                    end
                end
                LEAD_SPACE: begin
                    if (ev) begin
                        if (mark_start && in_win(dur, LS_MIN, LS_MAX)) begin
                            state  <= BIT_MARK;
                            bitcnt <= 5'd0;
                            rpt    <= 1'b0;
                        end else if (mark_start && in_win(dur, RS_MIN, RS_MAX)) begin
                            state <= STOP_MARK;
                            rpt   <= 1'b1;
                        end else begin
                            state         <= IDLE;
                            bus.frame_err <= 1'b1;
                        end
                    end
                end
                BIT_MARK: begin
                    if (ev) begin
                        if (mark_end && in_win(dur, BM_MIN, BM_MAX)) begin
                            state <= BIT_SPACE;
                        end else begin
                            state         <= IDLE;
                            bus.frame_err <= 1'b1;
                        end
                    end
                end
                BIT_SPACE: begin
                    if (ev) begin
                        if (mark_start && (in_win(dur, S0_MIN, S0_MAX) || in_win(dur, S1_MIN, S1_MAX))) begin
                            // LSB first: the first bit received ends up in sr[0].
                            sr     <= {!in_win(dur, S0_MIN, S0_MAX), sr[31:1]};
                            bitcnt <= bitcnt + 5'd1;
                            state  <= (bitcnt == 5'd31) ? STOP_MARK : BIT_MARK;
                        end else begin
                            state         <= IDLE;
                            bus.frame_err <= 1'b1;
                        end
                    end
                end
                STOP_MARK: begin
                    if (ev) begin
                        state <= IDLE;
                        if (!(mark_end && in_win(dur, BM_MIN, BM_MAX))) begin
                            bus.frame_err <= 1'b1;
                        end else if (rpt) begin
                            bus.repeat_pulse <= 1'b1;
`ifdef NEC_CHECK_EN
                        end else if (!inv_ok(sr)) begin
                            bus.frame_err <= 1'b1;
`endif
                        end else begin
                            bus.addr       <= sr[7:0];
                            bus.cmd        <= sr[23:16];
                            bus.data_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (!ev && timeout) begin
                state         <= IDLE;
                bus.frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nec_frame_decoder.sv
// Bench for nec_frame_decoder: the timer advances STEP microseconds per clock; frames are
// built as mark/space segment lists and outcomes predicted from the NEC frame rules.
module tb_nec_frame_decoder;
    import nec_pkg::*;

    localparam int STEP = 40;
    localparam int GAP  = 4000;
    localparam int M_FRAME   = 0;
    localparam int M_REPEAT  = 1;
    localparam int M_BADSP   = 2;
    localparam int M_TIMEOUT = 3;
    localparam int M_BADLEAD = 4;
`ifdef NEC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    nec_frame_decoder_if #(.CNT_W(33)) bus ();
    nec_frame_decoder #(.CNT_W(33)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural microsecond timer with junk in the ignored upper bits.
    logic [15:0] tcnt = 16'h0;
    logic [16:0] junk = 17'h0;
    always @(posedge clk) begin
        if (bus.tmr_rst)                        tcnt <= 16'h0;
        else if (tcnt > 16'(16'hFFFF - STEP))   tcnt <= 16'hFFFF;
        else                                    tcnt <= tcnt + 16'(STEP);
        junk <= 17'($urandom);
    end
    assign bus.count = {junk, tcnt};

    int n_checks = 0;
    int n_err    = 0;
    int dv_tot = 0, rp_tot = 0, fe_tot = 0, tr_tot = 0, tr_bad = 0;
    logic [7:0] cap_addr = 8'h0, cap_cmd = 8'h0;
    logic [7:0] mdl_addr = 8'h0, mdl_cmd = 8'h0;
    bit tr_skip = 1'b1, tr_prev = 1'b0;
    bit rnd = 1'b0;
    bit seg_m[$];
    int seg_d[$];

    always @(negedge clk) begin
        if (rst) begin
            tr_skip = 1'b1;
            tr_prev = 1'b0;
        end else begin
            if (bus.data_valid) begin
                dv_tot++;
                cap_addr = bus.addr;
                cap_cmd  = bus.cmd;
            end
            if (bus.repeat_pulse) rp_tot++;
            if (bus.frame_err)    fe_tot++;
            if (tr_skip) begin
                tr_skip = 1'b0;
                tr_prev = 1'b0;
            end else begin
                if (bus.tmr_rst) begin
                    tr_tot++;
                    if (tr_prev) tr_bad++;
                end
                tr_prev = bus.tmr_rst;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int nom, input int lo, input int hi);
        return rnd ? $urandom_range(lo, hi) : nom;
    endfunction

    task automatic add(input bit m, input int d);
        seg_m.push_back(m);
        seg_d.push_back((d / STEP) * STEP);
    endtask

    task automatic build(input int mode, input logic [31:0] w, input int k);
        seg_m.delete();
        seg_d.delete();
        if (mode == M_BADLEAD) begin
            add(1'b1, 5000);
            return;
        end
        add(1'b1, pick(9000, 8200, 9800));
        if (mode == M_REPEAT) begin
            add(1'b0, pick(2250, 2120, 2440));
            add(1'b1, pick(560, 520, 680));
            return;
        end
        add(1'b0, pick(4500, 4200, 4880));
        if (mode == M_TIMEOUT) begin
            add(1'b1, 14000);
            return;
        end
        for (int i = 0; i < 32; i++) begin
            add(1'b1, pick(560, 520, 680));
            if (mode == M_BADSP && i == k) begin
                add(1'b0, 1100);
                add(1'b1, pick(560, 520, 680));
                return;
            end
            add(1'b0, w[i] ? pick(1690, 1520, 1800) : pick(560, 520, 680));
        end
        add(1'b1, pick(560, 520, 680));
    endtask

    task automatic play();
        foreach (seg_m[i]) begin
            bus.ir_in = seg_m[i] ? 1'b0 : 1'b1;
            cycles(seg_d[i] / STEP);
        end
        bus.ir_in = 1'b1;
    endtask

    task automatic run_case(input string tag, input int mode, input logic [31:0] w, input int k);
        int dv0, rp0, fe0, tr0, marks;
        int e_dv, e_rp, e_fe;
        dv0 = dv_tot; rp0 = rp_tot; fe0 = fe_tot; tr0 = tr_tot;
        marks = 0;
        e_dv = 0; e_rp = 0; e_fe = 0;
        build(mode, w, k);
        foreach (seg_m[i]) if (seg_m[i]) marks++;
        play();
        cycles(GAP / STEP);
        if (mode == M_FRAME) begin
            if (CHK && !inv_ok(w)) begin
                e_fe = 1;
            end else begin
                e_dv = 1;
                mdl_addr = w[7:0];
                mdl_cmd  = w[23:16];
            end
        end else if (mode == M_REPEAT) begin
            e_rp = 1;
        end else begin
            e_fe = 1;
        end
        check({tag, ".data_valid"}, dv_tot - dv0, e_dv);
        check({tag, ".repeat"},     rp_tot - rp0, e_rp);
        check({tag, ".frame_err"},  fe_tot - fe0, e_fe);
        check({tag, ".tmr_rst"},    tr_tot - tr0, 2 * marks);
        check({tag, ".addr"},       bus.addr, mdl_addr);
        check({tag, ".cmd"},        bus.cmd, mdl_cmd);
        if (e_dv != 0) begin
            check({tag, ".cap_addr"}, cap_addr, mdl_addr);
            check({tag, ".cap_cmd"},  cap_cmd, mdl_cmd);
        end
    endtask

    initial begin
        int dv0, rp0, fe0;
        int mode, r, k;
        logic [7:0] a, c;
        logic [31:0] w;

        bus.ir_in = 1'b1;
        rst = 1'b1;
        cycles(5);
        check("reset.tmr_rst", bus.tmr_rst, 1);
        check("reset.addr", bus.addr, 0);
        check("reset.cmd", bus.cmd, 0);
        check("reset.data_valid", bus.data_valid, 0);
        check("reset.repeat", bus.repeat_pulse, 0);
        check("reset.frame_err", bus.frame_err, 0);
        rst = 1'b0;
        cycles(20);

        run_case("frame0408", M_FRAME, 32'hF708FB04, 0);
        run_case("repeat", M_REPEAT, 32'h0, 0);
        run_case("badbit10", M_BADSP, 32'h0, 10);
        run_case("after_err", M_FRAME, 32'hE41B8A75, 0);
        run_case("badinv", M_FRAME, 32'hF008FB04, 0);
        run_case("timeout", M_TIMEOUT, 32'h0, 0);
        run_case("badlead", M_BADLEAD, 32'h0, 0);

        // Abort mid-frame with reset while bit 20's mark is on the line.
        dv0 = dv_tot; rp0 = rp_tot; fe0 = fe_tot;
        build(M_FRAME, 32'h12345678, 0);
        while (seg_m.size() > 42) begin
            void'(seg_m.pop_back());
            void'(seg_d.pop_back());
        end
        play();
        bus.ir_in = 1'b0;
        cycles(6);
        rst = 1'b1;
        cycles(2);
        check("midrst.tmr_rst", bus.tmr_rst, 1);
        check("midrst.addr", bus.addr, 0);
        check("midrst.cmd", bus.cmd, 0);
        check("midrst.strobes", {bus.data_valid, bus.repeat_pulse, bus.frame_err}, 0);
        bus.ir_in = 1'b1;
        cycles(4);
        rst = 1'b0;
        mdl_addr = 8'h00;
        mdl_cmd  = 8'h00;
        cycles(GAP / STEP);
        check("midrst.after_strobes", (dv_tot - dv0) + (rp_tot - rp0) + (fe_tot - fe0), 0);
        check("midrst.after_addr", bus.addr, 0);
        run_case("post_rst", M_FRAME, 32'h9F60AD52, 0);

        rnd = 1'b1;
        for (int n = 0; n < 14; n++) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 31);
            a = 8'($urandom);
            c = 8'($urandom);
            w = ($urandom_range(0, 1) == 1) ? {~c, c, ~a, a} : 32'($urandom);
            case (r)
                5:       mode = M_REPEAT;
                6:       mode = M_BADSP;
                7:       mode = M_TIMEOUT;
                8:       mode = M_BADLEAD;
                default: mode = M_FRAME;
            endcase
            run_case($sformatf("rnd%0d", n), mode, w, k);
        end

        check("tmr_rst.width", tr_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/nec_frame_decoder.md
# nec_frame_decoder

- Decodes NEC infrared frames one stage downstream of the free-running microsecond `timer`.
- Samples the raw IR receiver pin and resets the timer on every IR edge.
- Classifies each mark/space by the timer's count at the next edge, then assembles the 32-bit frame.
- Emits address/command bytes with a valid strobe, a repeat-code strobe and an error strobe.

## Interface
Parameters:
- `CNT_W`, 33: width of `count` input from the timer (µs units, saturating at 16'hFFFF).
- `IR_ACTIVE_LOW`, 1: 1 = pin low during a mark (typical demodulating receiver).
- `LM_MIN`/`LM_MAX`, 8000/10000: leader mark window, µs.
- `LS_MIN`/`LS_MAX`, 4000/5000: leader space window, µs.
- `RS_MIN`/`RS_MAX`, 2000/2500: repeat space window, µs.
- `BM_MIN`/`BM_MAX`, 400/750: bit/stop mark window, µs.
- `S0_MIN`/`S0_MAX`, 400/750: logic-0 space window, µs.
- `S1_MIN`/`S1_MAX`, 1400/1900: logic-1 space window, µs.
- `TIMEOUT`, 12000: max phase length outside IDLE, µs.

Ports:
- `clk` in 1: system clock, 50 MHz (same as timer).
- `rst` in 1: asynchronous, active-high reset.
- `ir_in` in 1: raw asynchronous IR receiver pin.
- `count` in CNT_W: timer count, µs since last `tmr_rst`.
- `tmr_rst` out 1: one-cycle pulse that clears the timer.
- `addr` out 8: decoded address byte.
- `cmd` out 8: decoded command byte.
- `data_valid` out 1: one-cycle pulse when `addr`/`cmd` are updated.
- `repeat_pulse` out 1: one-cycle pulse on a valid repeat code.
- `frame_err` out 1: one-cycle pulse on any timing or check failure.

## Operation
- Input stage: `ir_in` passes through a 2-FF synchroniser, is polarity-normalised to `mark`, and edge-detected. Each mark-start or mark-end edge is an event.
- On every event: `tmr_rst` pulses, and the phase that just ended is measured as `dur = count[15:0]` sampled in the same cycle. Only comparisons with inclusive MIN..MAX bounds are used.
- FSM states and transitions:
  - IDLE: mark start → LEAD_MARK. Events other than mark start are ignored.
  - LEAD_MARK: mark end with dur in LM → LEAD_SPACE; otherwise error.
  - LEAD_SPACE: mark start with dur in LS → BIT_MARK (clear `bitcnt`, `rpt` = 0). With dur in RS → STOP_MARK (`rpt` = 1). Otherwise error.
  - BIT_MARK: mark end with dur in BM → BIT_SPACE; otherwise error.
  - BIT_SPACE: mark start with dur in S0 shifts in 0, in S1 shifts in 1, otherwise error. Bits enter LSB first into a 32-bit shift register, and `bitcnt` increments. If `bitcnt` == 31 → STOP_MARK; else → BIT_MARK.
  - STOP_MARK: mark end with dur in BM → IDLE, then:
    - if `rpt`, pulse `repeat_pulse`;
    - else load `addr` = sr[7:0] and `cmd` = sr[23:16], and pulse `data_valid`.
- Error: pulse `frame_err`, go to IDLE, and leave `addr`/`cmd` unchanged.
- Timeout: in any non-IDLE state, `count` ≥ TIMEOUT with no event → error.
- Events arriving in the same cycle as a timeout: the event takes priority.
- After an error, a new mark start is required to restart. An error raised on a mark start does not itself re-enter LEAD_MARK.

## Timing
- Reset values: `tmr_rst`=1 (timer held cleared during reset), `addr`=0, `cmd`=0, `data_valid`=0, `repeat_pulse`=0, `frame_err`=0, state IDLE, shift register 0, synchroniser FFs at the idle pin level.
- Edge-to-event latency: 3 clk (2 sync + 1 edge register). This latency is equal on both edges, so durations are unbiased.
- `tmr_rst` is high exactly 1 clk per event and is registered.
- Outputs are registered. The strobes rise 1 clk after the terminating event.
- `addr`/`cmd` hold until the next `data_valid`.
- The timer saturates at 16'hFFFF; `count` bits above [15:0] are ignored.
- `rst` asserted mid-frame aborts immediately. No strobe is issued.

## Configuration
- `NEC_CHECK_EN` defined: at STOP_MARK, require sr[15:8] == ~sr[7:0] and sr[31:24] == ~sr[23:16]. On mismatch, pulse `frame_err` instead of `data_valid`.
- `NEC_CHECK_EN` undefined: no inverse checks. `data_valid` is issued for any well-timed 32-bit frame (extended-NEC tolerant).

## Structure
- Package `nec_pkg`: state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK) and default window/timeout constants.
- Sub-module `ir_sync_edge`: 2-FF synchroniser, polarity normalisation, rise/fall event pulses.

## Test plan
- Full frame addr=8'h04, cmd=8'h08 (bits sent with 560 µs marks, 560/1690 µs spaces) → one `data_valid`, `addr`=04, `cmd`=08, no `frame_err`.
- Valid frame followed by repeat code (9000 mark, 2250 space, 560 mark) → `repeat_pulse` once; `addr`/`cmd` unchanged.
- Bit 10 space stretched to 1100 µs → `frame_err` pulse, return to IDLE; a following valid frame decodes correctly.
- `NEC_CHECK_EN` defined, cmd inverse byte 8'hF0 with cmd=8'h08 → `frame_err`, no `data_valid`. Same stimulus with the macro undefined → `data_valid`, `cmd`=08.
- Line held in mark after leader space beyond 12000 µs → `frame_err` at the timeout, state IDLE.
- `rst` pulsed during bit 20 → all outputs at reset values; `tmr_rst` high during reset; no strobe afterwards until a new frame.
